// File: rtl/sweep_pkg.sv
// Shared definitions for the vector sweep controller and its MISR.
package sweep_pkg;
   localparam int          MISR_W    = 16;
   localparam logic [15:0] MISR_POLY = 16'h1021;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/vector_sweep_ctrl_if.sv
// Host-side bundle for the sweep controller: control inputs, DUT loop and results.
interface vector_sweep_ctrl_if #(parameter int N_IN = 9);
   logic            i_start;
   logic            i_pause;
   logic            i_dut_t;
   logic [N_IN-1:0] o_vec_out;
   logic            o_busy;
   logic            o_done;
   logic            o_sample_valid;
   logic [N_IN-1:0] o_sample_index;
   logic [N_IN:0]   o_ones_count;
   logic [15:0]     o_signature;

   modport master (
      output i_start, i_pause, i_dut_t,
      input  o_vec_out, o_busy, o_done, o_sample_valid,
             o_sample_index, o_ones_count, o_signature
   );

   modport slave (
      input  i_start, i_pause, i_dut_t,
      output o_vec_out, o_busy, o_done, o_sample_valid,
             o_sample_index, o_ones_count, o_signature
   );
endinterface

// File: rtl/vector_sweep_ctrl_misr16.sv
// 16-bit single-input MISR; seed loaded on reset or init, one shift per enable.
module misr16
   import sweep_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_init,
   input  logic [MISR_W-1:0] i_seed,
   input  logic              i_en,
   input  logic              i_din,
   output logic [MISR_W-1:0] o_sig
);
   logic [MISR_W-1:0] r_sig;

   // Shift-left with feedback of (msb ^ din) into the polynomial taps.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_init) begin
         r_sig <= i_seed;
      end else if (i_en) begin
         r_sig <= {r_sig[MISR_W-2:0], 1'b0} ^ ((r_sig[MISR_W-1] ^ i_din) ? MISR_POLY : '0);
      end
   end

   assign o_sig = r_sig;
endmodule

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-vector sweep sequencer with ones-count and MISR result.
//
// state     | meaning
// ST_IDLE   | waiting for start; results from the last sweep are held
// ST_WAIT   | vector applied, settle down-counter running
// ST_SAMPLE | dut_t captured this cycle, advance or finish
// ST_DONE   | one-cycle completion pulse
module vector_sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int          N_IN   = 9,
   parameter int          SETTLE = 1,
   parameter logic [15:0] SEED   = 16'h0000
) (
   input logic                i_clk,
   input logic                i_rst,
   vector_sweep_ctrl_if.slave bus
);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t          r_state, w_next;
   logic [N_IN-1:0] r_vec;
   logic [N_IN:0]   r_ones;
   logic [SW-1:0]   r_settle;
   logic            w_load;
   logic            w_sample;
   logic            w_last;
   logic [15:0]     w_sig;

   assign w_last = &r_vec;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next state and strobes; pause freezes everything except IDLE.
   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_sample = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_load = 1'b1;
               w_next = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!bus.i_pause && r_settle == '0) w_next = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (!bus.i_pause) begin
               w_sample = 1'b1;
               if (w_last)           w_next = ST_DONE;
               else if (SETTLE == 0) w_next = ST_SAMPLE;
               else                  w_next = ST_WAIT;
            end
         end
         ST_DONE: begin
            if (!bus.i_pause) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Vector counter, settle down-counter and ones accumulator.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vec    <= '0;
         r_ones   <= '0;
         r_settle <= '0;
      end else if (w_load) begin
         r_vec    <= '0;
         r_ones   <= '0;
         r_settle <= SW'(SETTLE - 1);
      end else if (w_sample) begin
         r_ones   <= r_ones + (N_IN+1)'(bus.i_dut_t);
         r_settle <= SW'(SETTLE - 1);
         if (!w_last) r_vec <= r_vec + 1'b1;
      end else if (r_state == ST_WAIT && !bus.i_pause && r_settle != '0) begin
         r_settle <= r_settle - 1'b1;
      end
   end

   misr16 u_misr (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_init (w_load),
      .i_seed (SEED),
      .i_en   (w_sample),
      .i_din  (bus.i_dut_t),
      .o_sig  (w_sig)
   );

   assign bus.o_vec_out      = r_vec;
   assign bus.o_sample_index = r_vec;
   assign bus.o_ones_count   = r_ones;
   assign bus.o_signature    = w_sig;
   assign bus.o_sample_valid = w_sample;
   assign bus.o_done         = (r_state == ST_DONE) && !bus.i_pause;
   assign bus.o_busy         = (r_state == ST_WAIT) || (r_state == ST_SAMPLE);
endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench: three controller instances (SETTLE = 1, 0, 2) on one clock.
module tb_vector_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic start [3];
   logic pause [3];
   int   mode  [3];

   vector_sweep_ctrl_if #(.N_IN(9)) b0 ();
   vector_sweep_ctrl_if #(.N_IN(9)) b1 ();
   vector_sweep_ctrl_if #(.N_IN(9)) b2 ();

   vector_sweep_ctrl #(.N_IN(9), .SETTLE(1), .SEED(16'h0000)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0));
   vector_sweep_ctrl #(.N_IN(9), .SETTLE(0), .SEED(16'h0000)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1));
   vector_sweep_ctrl #(.N_IN(9), .SETTLE(2), .SEED(16'hACE1)) u2 (.i_clk(clk), .i_rst(rst), .bus(b2));

   // Stand-in for the basicCircuit block, inputs a..i = v[0]..v[8].
   function automatic logic basic_t(input logic [8:0] v);
      logic a, b, c, d, e, f, g, h, i;
      {i, h, g, f, e, d, c, b, a} = v;
      return ((a & b) | (c ^ d)) ^ ((e | f) & ~g) ^ (h & i);
   endfunction

   function automatic logic dut_fn(input int md, input logic [8:0] v);
      case (md)
         1:       return &v;
         2:       return v[0];
         3:       return basic_t(v);
         default: return 1'b0;
      endcase
   endfunction

   function automatic int ref_sig(input int md, input logic [15:0] seed);
      logic [15:0] s;
      logic        t;
      s = seed;
      for (int k = 0; k < 512; k++) begin
         t = dut_fn(md, 9'(k));
         s = {s[14:0], 1'b0} ^ ((s[15] ^ t) ? 16'h1021 : 16'h0000);
      end
      return int'(s);
   endfunction

   function automatic int ref_ones(input int md);
      int c;
      c = 0;
      for (int k = 0; k < 512; k++) c += int'(dut_fn(md, 9'(k)));
      return c;
   endfunction

   assign b0.i_start = start[0];
   assign b1.i_start = start[1];
   assign b2.i_start = start[2];
   assign b0.i_pause = pause[0];
   assign b1.i_pause = pause[1];
   assign b2.i_pause = pause[2];
   assign b0.i_dut_t = dut_fn(mode[0], b0.o_vec_out);
   assign b1.i_dut_t = dut_fn(mode[1], b1.o_vec_out);
   assign b2.i_dut_t = dut_fn(mode[2], b2.o_vec_out);

   logic sv_w [3], done_w [3], busy_w [3], t_w [3];
   int   vec_w [3], idx_w [3], ones_w [3], sig_w [3];

   assign sv_w[0] = b0.o_sample_valid;  assign sv_w[1] = b1.o_sample_valid;  assign sv_w[2] = b2.o_sample_valid;
   assign done_w[0] = b0.o_done;        assign done_w[1] = b1.o_done;        assign done_w[2] = b2.o_done;
   assign busy_w[0] = b0.o_busy;        assign busy_w[1] = b1.o_busy;        assign busy_w[2] = b2.o_busy;
   assign t_w[0] = b0.i_dut_t;          assign t_w[1] = b1.i_dut_t;          assign t_w[2] = b2.i_dut_t;
   assign vec_w[0] = int'(b0.o_vec_out);      assign vec_w[1] = int'(b1.o_vec_out);      assign vec_w[2] = int'(b2.o_vec_out);
   assign idx_w[0] = int'(b0.o_sample_index); assign idx_w[1] = int'(b1.o_sample_index); assign idx_w[2] = int'(b2.o_sample_index);
   assign ones_w[0] = int'(b0.o_ones_count);  assign ones_w[1] = int'(b1.o_ones_count);  assign ones_w[2] = int'(b2.o_ones_count);
   assign sig_w[0] = int'(b0.o_signature);    assign sig_w[1] = int'(b1.o_signature);    assign sig_w[2] = int'(b2.o_signature);

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Runs one sweep; cyc counts cycles from the start edge to the cycle done is seen.
   task automatic run_sweep(input int s, input int md, input int p_at, input int p_len,
                            input bit spam, output int cyc, output int pulses,
                            output int max_run, output int one_idx, output int pbad);
      int  run, pleft;
      bit  ptrig;
      mode[s] = md;
      cyc = -1; pulses = 0; max_run = 0; run = 0; one_idx = -1; pbad = 0;
      pleft = 0; ptrig = 1'b0;
      @(negedge clk); start[s] = 1'b1;
      @(negedge clk); start[s] = 1'b0;
      for (int n = 1; n <= 5000; n++) begin
         if (sv_w[s]) begin
            pulses++; run++;
            if (run > max_run) max_run = run;
            if (t_w[s]) one_idx = idx_w[s];
         end else begin
            run = 0;
         end
         if (done_w[s]) begin
            cyc = n;
            break;
         end
         if (pleft > 0) begin
            if (vec_w[s] != p_at || sv_w[s] || done_w[s]) pbad++;
            pleft--;
            if (pleft == 0) pause[s] = 1'b0;
         end else if (!ptrig && p_at >= 0 && busy_w[s] && !sv_w[s] && vec_w[s] == p_at) begin
            pause[s] = 1'b1;
            ptrig    = 1'b1;
            pleft    = p_len;
         end
         if (spam) start[s] = (n % 7 == 0);
         @(negedge clk);
      end
      start[s] = 1'b0;
      pause[s] = 1'b0;
   endtask

   task automatic chk_reset(input int s, input int seed, input string tag);
      chk({tag, "_vec"},  vec_w[s],       0);
      chk({tag, "_busy"}, int'(busy_w[s]), 0);
      chk({tag, "_done"}, int'(done_w[s]), 0);
      chk({tag, "_sv"},   int'(sv_w[s]),   0);
      chk({tag, "_ones"}, ones_w[s],      0);
      chk({tag, "_sig"},  sig_w[s],       seed);
   endtask

   initial begin
      int cyc, pulses, max_run, one_idx, pbad, held_sig, sig_m2, guard;
      for (int k = 0; k < 3; k++) begin
         start[k] = 1'b0; pause[k] = 1'b0; mode[k] = 0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset(0, 16'h0000, "rst0");
      chk_reset(2, 16'hACE1, "rst2");

      // Reset in the middle of a sweep at vector 100.
      mode[0] = 2;
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      guard = 0;
      while (vec_w[0] != 100 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      chk("t1_reach100", int'(vec_w[0] == 100), 1);
      chk("t1_pre_ones", ones_w[0], 50);
      rst = 1'b1;
      @(negedge clk);
      chk_reset(0, 16'h0000, "t1");
      rst = 1'b0;
      @(negedge clk);

      // dut_t tied low.
      run_sweep(0, 0, -1, 0, 1'b0, cyc, pulses, max_run, one_idx, pbad);
      chk("t2_cycles", cyc, 1025);
      chk("t2_pulses", pulses, 512);
      chk("t2_ones", ones_w[0], 0);
      chk("t2_sig", sig_w[0], 16'h0000);
      chk("t2_vec_end", vec_w[0], 511);
      chk("t2_busy_at_done", int'(busy_w[0]), 0);
      @(negedge clk);
      chk("t2_done_1cyc", int'(done_w[0]), 0);

      // AND of all inputs: a single one at the last vector.
      run_sweep(0, 1, -1, 0, 1'b0, cyc, pulses, max_run, one_idx, pbad);
      chk("t3_and_ones", ones_w[0], 1);
      chk("t3_and_idx", one_idx, 511);
      chk("t3_and_sig", sig_w[0], ref_sig(1, 16'h0000));
      held_sig = sig_w[0];
      repeat (5) @(negedge clk);
      chk("t3_sig_hold", sig_w[0], held_sig);
      chk("t3_ones_hold", ones_w[0], 1);

      // dut_t = a.
      run_sweep(0, 2, -1, 0, 1'b0, cyc, pulses, max_run, one_idx, pbad);
      chk("t3_a_ones", ones_w[0], 256);
      sig_m2 = ref_sig(2, 16'h0000);
      chk("t3_a_sig", sig_w[0], sig_m2);

      // Zero settle with start spammed during the sweep.
      run_sweep(1, 2, -1, 0, 1'b1, cyc, pulses, max_run, one_idx, pbad);
      chk("t4_cycles", cyc, 513);
      chk("t4_pulses", pulses, 512);
      chk("t4_run", max_run, 512);
      chk("t4_ones", ones_w[1], 256);
      chk("t4_sig", sig_w[1], sig_m2);

      // Pause for 50 cycles on vector 37.
      run_sweep(0, 2, 37, 50, 1'b0, cyc, pulses, max_run, one_idx, pbad);
      chk("t5_cycles", cyc, 1075);
      chk("t5_frozen", pbad, 0);
      chk("t5_pulses", pulses, 512);
      chk("t5_ones", ones_w[0], 256);
      chk("t5_sig", sig_w[0], sig_m2);

      // basicCircuit model, settle of 2, nonzero seed.
      run_sweep(2, 3, -1, 0, 1'b0, cyc, pulses, max_run, one_idx, pbad);
      chk("t6_cycles", cyc, 1537);
      chk("t6_pulses", pulses, 512);
      chk("t6_ones", ones_w[2], ref_ones(3));
      chk("t6_sig", sig_w[2], ref_sig(3, 16'hACE1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
